scr1_ahb_mem_responder: RTL and testbench

SCR1_AHB_MEM_RESPONDER -- requirements
Module: scr1_ahb_mem_responder

---
 rtl/scr1_ahb_mem_responder.sv | 139 +++++++++++++
 tb/tb_scr1_ahb_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_ahb_mem_responder.sv
// AHB-Lite memory slave with a programmable wait-state pattern.
// Storage is byte-lane RAM with registered reads. Misaligned, oversized or
// out-of-range transfers get the two-cycle ERROR response.
module scr1_ahb_mem_responder #(
    parameter int SCR1_MEM_POWER_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] stall_pattern_in,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    output logic        hready,
    output logic [31:0] hrdata,
    output logic        hresp
);

    localparam int          IDX_W     = SCR1_MEM_POWER_SIZE - 2;
    localparam int          DEPTH     = 1 << IDX_W;
    localparam logic [32:0] MEM_LIMIT = 33'd1 << SCR1_MEM_POWER_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_q;
    logic [31:0]        stall_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         off_q;
    logic [1:0]         size_q;
    logic               write_q;

    logic               bus_ready;
    logic               data_done;
    logic               accept;
    logic               req_ok;
    logic               misaligned;
    logic               in_range;
    logic               mem_we;
    logic [3:0]         byte_en;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        rdata_w;

    // Slave is ready when idle, in the last error cycle, or in a data cycle
    // whose current stall bit says "complete".
    assign data_done = (state_q == ST_DATA) && stall_q[0];
    assign bus_ready = (state_q == ST_IDLE) || (state_q == ST_ERR2) || data_done;

    // Only NONSEQ/SEQ start a transfer; IDLE/BUSY simply see a ready bus.
    assign accept = !rst && bus_ready && ((htrans == 2'b10) || (htrans == 2'b11));

    assign misaligned = ((hsize == 3'd1) && haddr[0]) ||
                        ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    assign in_range   = ({1'b0, haddr} < MEM_LIMIT);
    assign req_ok     = (hsize <= 3'd2) && !misaligned && in_range;

    // A write commits on its completing data cycle; reset abandons it.
    assign mem_we = !rst && data_done && write_q;

    // The RAM read port follows the incoming address on acceptance so the
    // data is already registered when the data phase starts.
    assign rd_idx = accept ? haddr[SCR1_MEM_POWER_SIZE-1:2] : idx_q;

    // Byte-lane selection from the latched size and low address bits.
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            2'd0:    byte_en = 4'b0001 << off_q;
            2'd1:    byte_en = off_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Control FSM and wait-state rotator; the rotator only advances in DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stall_q <= (stall_pattern_in == 32'h0) ? 32'hFFFF_FFFF : stall_pattern_in;
        end else begin
            if (state_q == ST_DATA) begin
                stall_q <= {stall_q[0], stall_q[31:1]};
            end
            if (accept) begin
                state_q <= req_ok ? ST_DATA : ST_ERR1;
            end else begin
                case (state_q)
                    ST_DATA: if (stall_q[0]) state_q <= ST_IDLE;
                    ST_ERR1: state_q <= ST_ERR2;
                    ST_ERR2: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Address-phase attributes held for the whole data phase.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= haddr[SCR1_MEM_POWER_SIZE-1:2];
            off_q   <= haddr[1:0];
            size_q  <= hsize[1:0];
            write_q <= hwrite;
        end
    end

    // One byte-wide RAM per lane. A read of the word being written on the
    // same edge takes the new byte, so back-to-back write/read sees fresh data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rd_q;

            // Lane write plus registered read with same-edge write forwarding.
            always_ff @(posedge clk) begin
                if (mem_we && byte_en[gi]) begin
                    mem_q[idx_q] <= hwdata[8*gi +: 8];
                end
                if (mem_we && byte_en[gi] && (idx_q == rd_idx)) begin
                    rd_q <= hwdata[8*gi +: 8];
                end else begin
                    rd_q <= mem_q[rd_idx];
                end
            end

            assign rdata_w[8*gi +: 8] = rd_q;
        end
    endgenerate

    assign hready = rst ? 1'b1 : bus_ready;
    assign hresp  = !rst && ((state_q == ST_ERR1) || (state_q == ST_ERR2));
    assign hrdata = (!rst && data_done && !write_q) ? rdata_w : 32'h0;

endmodule

// File: tb/tb_scr1_ahb_mem_responder.sv
// Directed bench for scr1_ahb_mem_responder: the driver queues the expected
// response of each transfer, and a negedge monitor checks every data phase.
module tb_scr1_ahb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_pattern_in;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;

    always #5 clk = ~clk;

    scr1_ahb_mem_responder #(.SCR1_MEM_POWER_SIZE(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_pattern_in (stall_pattern_in),
        .hsize            (hsize),
        .htrans           (htrans),
        .haddr            (haddr),
        .hwrite           (hwrite),
        .hwdata           (hwdata),
        .hready           (hready),
        .hrdata           (hrdata),
        .hresp            (hresp)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          waits;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] next_wdata = 32'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: follows data phases and compares against the queue head.
    logic active = 1'b0;
    int   wait_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            active   = 1'b0;
            wait_cnt = 0;
        end else begin
            if (active) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL orphan data phase: hready=%0b hresp=%0b with no expected entry", hready, hresp);
                    active = 1'b0;
                end else if (!hready) begin
                    check({sb_q[0].name, " wait hresp"}, {31'h0, hresp}, {31'h0, sb_q[0].err});
                    check({sb_q[0].name, " wait hrdata"}, hrdata, 32'h0);
                    wait_cnt++;
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, " hresp"}, {31'h0, hresp}, {31'h0, e.err});
                    check({e.name, " hrdata"}, hrdata, e.data);
                    check({e.name, " waits"}, wait_cnt, e.waits);
                    $display("txn %s: hresp=%0b hrdata=%h waits=%0d", e.name, hresp, hrdata, wait_cnt);
                    active = 1'b0;
                end
            end
            if (hready && htrans[1]) begin
                active   = 1'b1;
                wait_cnt = 0;
            end
        end
    end

    task automatic wait_ready(input string nm);
        int k = 0;
        @(negedge clk);
        while (!hready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!hready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: hready=%0b, expected 1 within 100 cycles", nm, hready);
        end
    endtask

    // Issue one address phase (hwdata carries the previous write's data).
    task automatic xfer(input string nm, input logic [1:0] tr, input logic [31:0] a,
                        input logic [2:0] sz, input logic wr, input logic [31:0] wd,
                        input logic err, input logic [31:0] exp_data, input int waits);
        exp_t e;
        htrans = tr;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
        hwdata = next_wdata;
        e = '{err, exp_data, waits, nm};
        sb_q.push_back(e);
        wait_ready(nm);
        @(posedge clk);
        #1;
        next_wdata = wd;
    endtask

    task automatic bus_idle();
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = next_wdata;
        wait_ready("idle");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pattern);
        rst              = 1'b1;
        stall_pattern_in = pattern;
        htrans           = 2'b00;
        hwrite           = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("reset hready", {31'h0, hready}, 32'h1);
        check("reset hresp", {31'h0, hresp}, 32'h0);
        check("reset hrdata", hrdata, 32'h0);
        rst              = 1'b0;
        stall_pattern_in = 32'h0000_0002;
        next_wdata       = 32'h0;
    endtask

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    initial begin
        rst = 1'b1; stall_pattern_in = 32'h0; hsize = 3'd0; htrans = 2'b00;
        haddr = 32'h0; hwrite = 1'b0; hwdata = 32'h0;

        // Zero-wait pattern, write then back-to-back read of the same word.
        do_reset(32'hFFFF_FFFF);
        xfer("wr100",  NS, 32'h100, 3'd2, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 0);
        xfer("rd100",  NS, 32'h100, 3'd2, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 0);
        bus_idle();

        // Byte and halfword lane merging; stray bits in other lanes are ignored.
        xfer("wr200",  NS, 32'h200, 3'd2, 1'b1, 32'h1122_3344, 1'b0, 32'h0, 0);
        xfer("wrb201", SQ, 32'h201, 3'd0, 1'b1, 32'h1234_AA56, 1'b0, 32'h0, 0);
        xfer("wrh202", SQ, 32'h202, 3'd1, 1'b1, 32'hBBCC_9999, 1'b0, 32'h0, 0);
        xfer("rd200",  NS, 32'h200, 3'd2, 1'b0, 32'h0,         1'b0, 32'hBBCC_AA44, 0);
        bus_idle();

        // Error responses; the targeted words must stay intact.
        xfer("wr204",   NS, 32'h204,     3'd2, 1'b1, 32'h7766_5544, 1'b0, 32'h0, 0);
        xfer("wr000",   NS, 32'h000,     3'd2, 1'b1, 32'h1357_9BDF, 1'b0, 32'h0, 0);
        xfer("errwh205",NS, 32'h205,     3'd1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
        xfer("errrh003",NS, 32'h003,     3'd1, 1'b0, 32'h0,         1'b1, 32'h0, 1);
        xfer("errww10k",NS, 32'h1_0000,  3'd2, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
        xfer("errrw10k",NS, 32'h1_0000,  3'd2, 1'b0, 32'h0,         1'b1, 32'h0, 1);
        xfer("errsz3",  NS, 32'h000,     3'd3, 1'b0, 32'h0,         1'b1, 32'h0, 1);
        xfer("rd204",   NS, 32'h204,     3'd2, 1'b0, 32'h0,         1'b0, 32'h7766_5544, 0);
        xfer("rd000",   NS, 32'h000,     3'd2, 1'b0, 32'h0,         1'b0, 32'h1357_9BDF, 0);
        bus_idle();

        // Pattern 0x5555_5554: bits 0,1 low then alternating from bit 2.
        // Memory is retained across this reset.
        do_reset(32'h5555_5554);
        xfer("st_rd100", NS, 32'h100, 3'd2, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 2);
        xfer("st_rd200", NS, 32'h200, 3'd2, 1'b0, 32'h0,         1'b0, 32'hBBCC_AA44, 1);
        xfer("st_rd100b",NS, 32'h100, 3'd2, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1);
        xfer("st_wr300", NS, 32'h300, 3'd2, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1);
        xfer("st_rd300", NS, 32'h300, 3'd2, 1'b0, 32'h0,         1'b0, 32'hCAFE_F00D, 1);
        bus_idle();
        xfer("st_err",   NS, 32'h003, 3'd1, 1'b0, 32'h0,         1'b1, 32'h0, 1);
        xfer("st_rd100c",NS, 32'h100, 3'd2, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1);
        bus_idle();

        // Reset in the middle of a long write wait: write must be dropped.
        do_reset(32'h0000_0001);
        xfer("ab_seed", NS, 32'h010, 3'd2, 1'b1, 32'h0BAD_CAFE, 1'b0, 32'h0, 0);
        xfer("ab_wr",   NS, 32'h010, 3'd2, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 31);
        htrans = 2'b00;
        hwdata = next_wdata;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst              = 1'b1;
        stall_pattern_in = 32'h0000_0001;
        sb_q.delete();
        @(posedge clk);
        #1;
        check("abort hready", {31'h0, hready}, 32'h1);
        check("abort hresp", {31'h0, hresp}, 32'h0);
        rst              = 1'b0;
        stall_pattern_in = 32'h0;
        next_wdata       = 32'h0;
        xfer("ab_rd010", NS, 32'h010, 3'd2, 1'b0, 32'h0, 1'b0, 32'h0BAD_CAFE, 0);
        bus_idle();

        // Zero pattern falls back to all-ones: everything completes at once.
        do_reset(32'h0000_0000);
        xfer("z_wr400",  NS, 32'h400, 3'd2, 1'b1, 32'h0102_0304, 1'b0, 32'h0, 0);
        xfer("z_rdb403", SQ, 32'h403, 3'd0, 1'b0, 32'h0,         1'b0, 32'h0102_0304, 0);
        xfer("z_rdh402", SQ, 32'h402, 3'd1, 1'b0, 32'h0,         1'b0, 32'h0102_0304, 0);
        xfer("z_wrb400", NS, 32'h400, 3'd0, 1'b1, 32'hFFFF_FF99, 1'b0, 32'h0, 0);
        xfer("z_rd400",  NS, 32'h400, 3'd2, 1'b0, 32'h0,         1'b0, 32'h0102_0399, 0);
        xfer("z_rd100",  NS, 32'h100, 3'd2, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 0);
        bus_idle();
        bus_idle();

        check("scoreboard drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
